// File: rtl/gen_dpfifo_pkg.sv
// gen_dpfifo_pkg: shared sizing helper, ready thresholds and accept bundle for gen_dpfifo
package gen_dpfifo_pkg;

    // Headroom below DP that each write port needs before it may push.
    // B needs one extra slot so it still fits when A pushes in the same cycle.
    localparam int READY_A_GAP = 1;
    localparam int READY_B_GAP = 2;

    // Effective per-cycle actions after readiness and bypass are resolved
    typedef struct packed {
        logic a;
        logic b;
        logic p;
    } acc_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/gen_dffren.sv
// gen_dffren: enabled D flop with asynchronous active-low reset to rstValue
module gen_dffren #(
    parameter int DW = 32,
    parameter logic [DW-1:0] rstValue = '0
)(
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout,
    input  logic          en,
    input  logic          CLK,
    input  logic          RSTn
);

    // hold value unless enabled; reset is asynchronous
    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn) qout <= rstValue;
        else if (en) qout <= dnxt;

endmodule

// File: rtl/gen_dpfifo.sv
// gen_dpfifo: two-write-port (A before B) one-read-port flop FIFO; GEN_DPFIFO_BYPASS_EN adds an empty-FIFO dnxta->qout bypass
module gen_dpfifo
    import gen_dpfifo_pkg::*;
#(
    parameter int DW = 32,
    parameter int DP = 4,
    localparam int AW = clog2(DP),
    localparam int CW = AW + 1
)(
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          flush,
    input  logic          push_a,
    input  logic [DW-1:0] dnxta,
    output logic          ready_a,
    input  logic          push_b,
    input  logic [DW-1:0] dnxtb,
    output logic          ready_b,
    output logic          valid,
    input  logic          pop,
    output logic [DW-1:0] qout,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem [DP];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [CW-1:0] cnt_nxt;
    logic          acc_a, acc_b, acc_p, byp_pop;
    acc_t          acc;

    // readies look only at registered occupancy so they never depend on pop
    assign ready_a = count <= CW'(DP - READY_A_GAP);
    assign ready_b = count <= CW'(DP - READY_B_GAP);
    assign acc_a   = push_a & ready_a;
    assign acc_b   = push_b & ready_b;
    assign acc_p   = pop & valid;

`ifdef GEN_DPFIFO_BYPASS_EN
    logic byp;
    assign byp     = (count == '0) & push_a;
    assign valid   = (count != '0) | byp;
    assign qout    = byp ? dnxta : mem[rd_ptr];
    assign byp_pop = byp & pop;
`else
    assign valid   = count != '0;
    assign qout    = mem[rd_ptr];
    assign byp_pop = 1'b0;
`endif

    // a bypassed-and-popped A word neither lands in storage nor moves rd_ptr
    always_comb begin
        acc.a   = acc_a & ~byp_pop;
        acc.b   = acc_b;
        acc.p   = acc_p & ~byp_pop;
        wr_nxt  = flush ? '0 : wr_ptr + AW'(acc.a) + AW'(acc.b);
        rd_nxt  = flush ? '0 : rd_ptr + AW'(acc.p);
        cnt_nxt = flush ? '0 : count + CW'(acc.a) + CW'(acc.b) - CW'(acc.p);
    end

    // storage write: A at wr_ptr, B right behind it when both are taken
    always_ff @(posedge CLK)
        if (!flush) begin
            if (acc.a) mem[wr_ptr] <= dnxta;
            if (acc.b) mem[wr_ptr + AW'(acc.a)] <= dnxtb;
        end

    gen_dffren #(.DW(AW), .rstValue('0)) u_wr_ptr (
        .dnxt(wr_nxt), .qout(wr_ptr), .en(1'b1), .CLK(CLK), .RSTn(RSTn)
    );

    gen_dffren #(.DW(AW), .rstValue('0)) u_rd_ptr (
        .dnxt(rd_nxt), .qout(rd_ptr), .en(1'b1), .CLK(CLK), .RSTn(RSTn)
    );

    gen_dffren #(.DW(CW), .rstValue('0)) u_count (
        .dnxt(cnt_nxt), .qout(count), .en(1'b1), .CLK(CLK), .RSTn(RSTn)
    );

endmodule

// File: tb/tb_gen_dpfifo.sv
// tb_gen_dpfifo: directed stimulus for gen_dpfifo checked against a queue model every cycle plus literal expectations
module tb_gen_dpfifo;

    localparam int DP = 4;
`ifdef GEN_DPFIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK, RSTn, flush, push_a, push_b, pop;
    logic [31:0] dnxta, dnxtb, qout;
    logic        ready_a, ready_b, valid;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    logic [31:0] q[$];

    gen_dpfifo #(.DW(32), .DP(DP)) dut (
        .CLK(CLK), .RSTn(RSTn), .flush(flush),
        .push_a(push_a), .dnxta(dnxta), .ready_a(ready_a),
        .push_b(push_b), .dnxtb(dnxtb), .ready_b(ready_b),
        .valid(valid), .pop(pop), .qout(qout), .count(count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference queue: occupancy and order from the push/pop rules
    always @(posedge CLK or negedge RSTn) begin
        int n;
        bit aa, ab, eb;
        if (!RSTn) q.delete();
        else if (flush) q.delete();
        else begin
            n  = q.size();
            eb = BYP && n == 0 && push_a;
            aa = push_a && n <= DP - 1;
            ab = push_b && n <= DP - 2;
            if (eb && pop) begin
                if (ab) q.push_back(dnxtb);
            end else begin
                if (pop && n > 0) void'(q.pop_front());
                if (aa) q.push_back(dnxta);
                if (ab) q.push_back(dnxtb);
            end
        end
    end

    // every-cycle comparison against the model, away from the clock edge
    always @(negedge CLK) begin
        int n;
        bit eb;
        n  = q.size();
        eb = BYP && n == 0 && push_a;
        chk("m_count", 32'(count), 32'(n));
        chk("m_ready_a", 32'(ready_a), 32'(n <= DP - 1));
        chk("m_ready_b", 32'(ready_b), 32'(n <= DP - 2));
        chk("m_valid", 32'(valid), 32'(n > 0 || eb));
        if (eb) chk("m_qout_byp", qout, dnxta);
        else if (n > 0) chk("m_qout", qout, q[0]);
    end

    task automatic drive(input logic pa, input logic [31:0] da, input logic pb,
                         input logic [31:0] db, input logic p, input logic f);
        push_a = pa; dnxta = da; push_b = pb; dnxtb = db; pop = p; flush = f;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        push_a = 1'b0; push_b = 1'b0; pop = 1'b0; flush = 1'b0;
    endtask

    initial begin
        logic [31:0] e4[4];
        RSTn = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_ready_a", 32'(ready_a), 1);
        chk("rst_ready_b", 32'(ready_b), 1);
        repeat (2) @(posedge CLK);
        #1 RSTn = 1'b1;

        drive(1, 32'hA0, 0, 0, 0, 0); tick();
        chk("a0_valid", 32'(valid), 1);
        chk("a0_qout", qout, 32'hA0);
        chk("a0_count", 32'(count), 1);
        drive(0, 0, 0, 0, 1, 0); tick();
        chk("a0_pop_count", 32'(count), 0);
        chk("a0_pop_valid", 32'(valid), 0);

        drive(1, 32'h11, 1, 32'h22, 0, 0); tick();
        chk("dual1_count", 32'(count), 2);
        drive(1, 32'h11, 1, 32'h22, 0, 0); tick();
        chk("dual2_count", 32'(count), 4);
        chk("full_ready_a", 32'(ready_a), 0);
        chk("full_ready_b", 32'(ready_b), 0);
        e4 = '{32'h11, 32'h22, 32'h11, 32'h22};
        for (int i = 0; i < 4; i++) begin
            chk("dual_order", qout, e4[i]);
            drive(0, 0, 0, 0, 1, 0); tick();
        end
        chk("dual_empty", 32'(count), 0);

        for (int i = 1; i <= 3; i++) begin
            drive(1, 32'(i), 0, 0, 0, 0); tick();
        end
        chk("c3_ready_a", 32'(ready_a), 1);
        chk("c3_ready_b", 32'(ready_b), 0);
        drive(1, 32'h44, 1, 32'h55, 0, 0); tick();
        chk("c3_count", 32'(count), 4);
        e4 = '{32'h1, 32'h2, 32'h3, 32'h44};
        for (int i = 0; i < 4; i++) begin
            chk("c3_order", qout, e4[i]);
            drive(0, 0, 0, 0, 1, 0); tick();
        end
        chk("c3_empty", 32'(valid), 0);

        drive(1, 32'h60, 0, 0, 0, 0); tick();
        for (int i = 1; i <= 5; i++) begin
            chk("wrap_head", qout, 32'h60 + 32'(i - 1));
            drive(1, 32'h60 + 32'(i), 0, 0, 1, 0); tick();
            chk("wrap_count", 32'(count), 1);
        end
        chk("wrap_last", qout, 32'h65);
        drive(0, 0, 0, 0, 1, 0); tick();

        drive(1, 32'h71, 1, 32'h72, 0, 0); tick();
        drive(1, 32'h73, 0, 0, 0, 0); tick();
        chk("fl_pre", 32'(count), 3);
        drive(1, 32'h99, 0, 0, 1, 1); tick();
        chk("fl_count", 32'(count), 0);
        chk("fl_valid", 32'(valid), 0);
        drive(1, 32'h77, 0, 0, 0, 0); tick();
        chk("fl_after", qout, 32'h77);
        chk("fl_after_cnt", 32'(count), 1);
        drive(0, 0, 0, 0, 1, 0); tick();

        drive(1, 32'h5A, 0, 0, 1, 0);
        #1;
        if (BYP) begin
            chk("byp_valid", 32'(valid), 1);
            chk("byp_qout", qout, 32'h5A);
            tick();
            chk("byp_count", 32'(count), 0);
        end else begin
            chk("nobyp_valid", 32'(valid), 0);
            tick();
            chk("nobyp_count", 32'(count), 1);
            drive(0, 0, 0, 0, 1, 0); tick();
        end
        drive(1, 32'hC1, 1, 32'hC2, 1, 0); tick();
        if (BYP) begin
            chk("bypb_count", 32'(count), 1);
            chk("bypb_qout", qout, 32'hC2);
        end else begin
            chk("nobypb_count", 32'(count), 2);
            chk("nobypb_qout", qout, 32'hC1);
        end
        drive(0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 1, 0); tick();
        chk("drain", 32'(count), 0);

        drive(1, 32'hD1, 1, 32'hD2, 0, 0); tick();
        RSTn = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_valid", 32'(valid), 0);
        #2 RSTn = 1'b1;
        drive(1, 32'hAB, 0, 0, 0, 0); tick();
        chk("arst_resume", qout, 32'hAB);
        chk("arst_resume_cnt", 32'(count), 1);
        drive(0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 1, 0); tick();
        chk("empty_pop", 32'(count), 0);

        @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gen_dpfifo.md
# gen_dpfifo

Two-write-port, one-read-port synchronous FIFO for Rift2Core pipeline boundaries where two producers can retire into one consumer in the same cycle, such as dual-issue writeback into a commit queue. Port A has priority: when both ports push in one cycle, A's word is enqueued ahead of B's. The block sits upstream of the `gen_dpdffren`-style registered stages and presents a plain valid/pop interface to them. Storage and pointers are flops; there are no SRAM macros.

## Interface
- `DW`, 32, data width in bits.
- `DP`, 4, depth in words; a power of two, at least 2.
- `AW`, clog2(DP), pointer width; derived, not overridden.

- `CLK`  in  1  clock; all state updates on the rising edge.
- `RSTn`  in  1  reset; asynchronous and active-low.
- `flush`  in  1  synchronous clear of all entries.
- `push_a`  in  1  enqueue request, port A.
- `dnxta`  in  DW  data, port A.
- `ready_a`  out  1  port A may push; high when count ≤ DP-1.
- `push_b`  in  1  enqueue request, port B.
- `dnxtb`  in  DW  data, port B.
- `ready_b`  out  1  port B may push; high when count ≤ DP-2, so B has room even if A pushes in the same cycle.
- `valid`  out  1  FIFO is non-empty, or bypass is active.
- `pop`  in  1  dequeue the head word.
- `qout`  out  DW  head word.
- `count`  out  AW+1  current occupancy, 0..DP.

## Operation
- Reset values: `rd_ptr`=0, `wr_ptr`=0, `count`=0, `valid`=0, `ready_a`=1, `ready_b`=1. Storage contents are not reset; `qout` is don't-care while `valid`=0.
- Accepted pushes:
  - `acc_a` = `push_a & ready_a`.
  - `acc_b` = `push_b & ready_b`.
  - A push presented while its ready is low is dropped silently; state is unchanged.
- Write order:
  - `acc_a` alone writes `mem[wr_ptr]`.
  - `acc_b` alone writes `mem[wr_ptr]`.
  - Both write A to `mem[wr_ptr]` and B to `mem[wr_ptr+1]`.
  - `wr_ptr` advances by `acc_a + acc_b`. Pointer arithmetic is modulo DP and wraps naturally.
- Pop:
  - `acc_p` = `pop & valid`.
  - `rd_ptr` advances by 1 when `acc_p` is high.
  - `pop` while `valid`=0 is ignored.
- Count: `count_nxt` = `count + acc_a + acc_b - acc_p`, computed at AW+1 bits. The result never leaves 0..DP.
- Simultaneous events:
  - Push and pop in the same cycle are both honoured.
  - `ready_*` depend only on registered `count`, never on the same-cycle `pop`. This is conservative and keeps the ready paths free of combinational loops.
- Flush:
  - Next state: pointers=0, `count`=0.
  - Flush has priority over every push and pop in the same cycle; those are discarded.
- Reset mid-operation: all contents are lost immediately (asynchronous reset). The block resumes from the reset state on the first edge after `RSTn` rises.

## Timing
- Latency without bypass: a word pushed at edge N is visible on `qout` with `valid`=1 after edge N. It can be popped at edge N+1 at the earliest.
- `qout` = `mem[rd_ptr]`, a mux from registered state with no input-to-output combinational path.
- Full boundary:
  - At count=DP-1: `ready_a`=1, `ready_b`=0.
  - At count=DP: both readies are 0.
- Empty boundary: at count=0, `valid`=0 and `pop` has no effect.

## Configuration
- Macro: `GEN_DPFIFO_BYPASS_EN`.
- Defined (bypass active when count=0 and `push_a`=1):
  - `valid`=1 and `qout`=`dnxta` in the same cycle.
  - If `pop` is also high, the word is consumed directly and is not written. `wr_ptr`, `rd_ptr` and `count` are updated as if A had not pushed.
  - `acc_b` in that cycle is still enqueued normally.
  - Port B never bypasses.
- Undefined: one-cycle latency as above, with no `dnxta`→`qout` path.

## Structure
- Shared package/header holds:
  - the clog2 constant function used to derive `AW`;
  - the ready thresholds, expressed as DP-relative localparams.
- Pointer and count registers reuse the existing `gen_dffren`, one instance each with `rstValue` 0.
- Storage is a local DP×DW register array written under `acc_a`/`acc_b`.
- No other sub-module is needed.

## Test plan
- Reset, then push_a 0xA0 alone → after 1 edge: `valid`=1, `qout`=0xA0, `count`=1. Pop → `count`=0, `valid`=0.
- DP=4, both ports push A=0x11 and B=0x22 for 2 cycles:
  - after edge 1: `count`=2;
  - after edge 2: `count`=4 and `ready_a`=`ready_b`=0;
  - 4 pops → `qout` reads 0x11, 0x22, 0x11, 0x22 in that order.
- count=3, push_a and push_b both high → only A is accepted, `count`=4, and B's word never appears on `qout`.
- Wrap-around: 6 single pushes interleaved with pops at DP=4 → FIFO order is preserved across the pointer wrap, and `count` never exceeds 2.
- count=3, flush together with push_a and pop → after edge: `count`=0, `valid`=0, and the pushed word is discarded.
- With `GEN_DPFIFO_BYPASS_EN`, count=0, push_a 0x5A and pop in the same cycle:
  - the same cycle shows `valid`=1 and `qout`=0x5A;
  - after the edge, `count`=0.
